// File: rtl/vmem_pkg.sv
// Shared definitions for the video-memory arbiter and the engines it grants.
// The owner codes also appear on the engine side, which compares them with arb_state.
package vmem_pkg;

  // Owner codes carried on arb_state
  localparam logic [1:0] ARB_RD   = 2'b00;
  localparam logic [1:0] ARB_WR0  = 2'b01;
  localparam logic [1:0] ARB_WR1  = 2'b10;
  localparam logic [1:0] ARB_NONE = 2'b11;

  // Arbiter FSM encodings
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_GRANT     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  // Maps an owner code to the one-hot enable vector {wr1, wr0, rd}
  function automatic logic [2:0] arbOneHot(input logic [1:0] owner);
    case (owner)
      ARB_RD:  return 3'b001;
      ARB_WR0: return 3'b010;
      ARB_WR1: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tgl_sync_edge.sv
// Brings a memclk-domain completion toggle into pclk and turns each
// transition into a one-cycle event pulse, three pclk after the input edge.
// It has no reset so it keeps following the toggle level across an
// arbiter reset. A stale toggle then yields only a pulse that the idle
// arbiter ignores.
module tgl_sync_edge (
  input  logic pclk,
  input  logic tgl_i,
  output logic evt_o
);

  logic meta_q;
  logic sync_q;
  logic last_q;
  logic evt_q;

  // Two-flop synchronizer, then compare against the previous synced level
  always_ff @(posedge pclk) begin
    meta_q <= tgl_i;
    sync_q <= meta_q;
    last_q <= sync_q;
    evt_q  <= sync_q ^ last_q;
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/vmem_arbiter.sv
// Grants the shared DDR controller ports to the display read engine or one
// of the two capture write engines. It grants one engine at a time, holds
// the grant until that engine's done toggle arrives or a timeout fires,
// then enforces an idle gap before the next grant.
// Optional grant statistics: define VMEM_ARB_STATS_EN.
module vmem_arbiter
  import vmem_pkg::*;
#(
  parameter int unsigned GAP_CYC    = 4,
  parameter int unsigned TIMEOUT    = 4095,
  parameter int unsigned STARVE_LIM = 3
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic        wr0_req,
  input  logic        wr1_req,
  input  logic        rd_done_tgl,
  input  logic        wr0_done_tgl,
  input  logic        wr1_done_tgl,
  output logic        rd_en,
  output logic        wr0_en,
  output logic        wr1_en,
  output logic [1:0]  arb_state,
  output logic        busy,
  output logic        timeout_err
`ifdef VMEM_ARB_STATS_EN
  ,
  output logic [15:0] rd_gnt_cnt,
  output logic [15:0] wr0_gnt_cnt,
  output logic [15:0] wr1_gnt_cnt,
  output logic [15:0] max_wait
`endif
);

  localparam int unsigned GAP_LAST_I = GAP_CYC - 1;
  localparam int unsigned TMO_LAST_I = TIMEOUT - 1;
  localparam logic [7:0]  GAP_LAST   = GAP_LAST_I[7:0];
  localparam logic [11:0] TMO_LAST   = TMO_LAST_I[11:0];
  localparam logic [3:0]  STARVE_CAP = STARVE_LIM[3:0];

  logic [1:0]  state_q,     state_d;
  logic [1:0]  winner_q,    winner_d;
  logic [2:0]  en_q,        en_d;
  logic [1:0]  arbState_q,  arbState_d;
  logic [11:0] timer_q,     timer_d;
  logic [7:0]  gapCnt_q,    gapCnt_d;
  logic [3:0]  starveCnt_q, starveCnt_d;
  logic        rrPtr_q,     rrPtr_d;
  logic        tmoErr_q,    tmoErr_d;

  logic rdEvt, wr0Evt, wr1Evt;
  logic ownerDone, tmoHit, relNow;
  logic wrPend, pickWr;
  logic [1:0] wrPick;

  tgl_sync_edge uRdSync  (.pclk(pclk), .tgl_i(rd_done_tgl),  .evt_o(rdEvt));
  tgl_sync_edge uWr0Sync (.pclk(pclk), .tgl_i(wr0_done_tgl), .evt_o(wr0Evt));
  tgl_sync_edge uWr1Sync (.pclk(pclk), .tgl_i(wr1_done_tgl), .evt_o(wr1Evt));

  // Only the current owner's completion counts; the others are dropped
  assign ownerDone = ((arbState_q == ARB_RD)  && rdEvt)  ||
                     ((arbState_q == ARB_WR0) && wr0Evt) ||
                     ((arbState_q == ARB_WR1) && wr1Evt);
  assign tmoHit    = (timer_q == TMO_LAST);
  assign relNow    = (state_q == ST_WAIT_DONE) && (ownerDone || tmoHit);

  // Writes win when rd is absent or has used up its starvation allowance
  assign wrPend = wr0_req || wr1_req;
  assign pickWr = wrPend && (!rd_req || (starveCnt_q == STARVE_CAP));
  assign wrPick = (wr0_req && wr1_req) ? (rrPtr_q ? ARB_WR1 : ARB_WR0)
                                       : (wr0_req ? ARB_WR0 : ARB_WR1);

  // Next-state logic for the grant FSM, fairness state and timers
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    en_d        = en_q;
    arbState_d  = arbState_q;
    timer_d     = timer_q;
    gapCnt_d    = gapCnt_q;
    starveCnt_d = starveCnt_q;
    rrPtr_d     = rrPtr_q;
    tmoErr_d    = tmoErr_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_req || wrPend) begin
          state_d = ST_GRANT;
          if (pickWr) begin
            winner_d    = wrPick;
            starveCnt_d = 4'd0;
            rrPtr_d     = (wrPick == ARB_WR0);
          end else begin
            winner_d = ARB_RD;
            if (wrPend && (starveCnt_q != STARVE_CAP)) begin
              starveCnt_d = starveCnt_q + 4'd1;
            end
          end
        end
      end
      ST_GRANT: begin
        en_d       = arbOneHot(winner_q);
        arbState_d = winner_q;
        timer_d    = 12'd0;
        state_d    = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (relNow) begin
          en_d       = 3'b000;
          arbState_d = ARB_NONE;
          gapCnt_d   = 8'd0;
          state_d    = ST_GAP;
          if (!ownerDone) begin
            tmoErr_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 12'd1;
        end
      end
      default: begin
        if (gapCnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gapCnt_d = gapCnt_q + 8'd1;
        end
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      winner_q    <= ARB_NONE;
      en_q        <= 3'b000;
      arbState_q  <= ARB_NONE;
      timer_q     <= 12'd0;
      gapCnt_q    <= 8'd0;
      starveCnt_q <= 4'd0;
      rrPtr_q     <= 1'b0;
      tmoErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      en_q        <= en_d;
      arbState_q  <= arbState_d;
      timer_q     <= timer_d;
      gapCnt_q    <= gapCnt_d;
      starveCnt_q <= starveCnt_d;
      rrPtr_q     <= rrPtr_d;
      tmoErr_q    <= tmoErr_d;
    end
  end

  assign rd_en       = en_q[0];
  assign wr0_en      = en_q[1];
  assign wr1_en      = en_q[2];
  assign arb_state   = arbState_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = tmoErr_q;

`ifdef VMEM_ARB_STATS_EN
  logic [15:0] rdCnt_q, wr0Cnt_q, wr1Cnt_q, maxWait_q;
  logic [15:0] waitLen;

  assign waitLen = {4'd0, timer_q} + 16'd1;

  // Per-port grant counters and longest grant duration
  always_ff @(posedge pclk) begin
    if (rst) begin
      rdCnt_q   <= 16'd0;
      wr0Cnt_q  <= 16'd0;
      wr1Cnt_q  <= 16'd0;
      maxWait_q <= 16'd0;
    end else begin
      if (state_q == ST_GRANT) begin
        case (winner_q)
          ARB_RD:  rdCnt_q  <= rdCnt_q + 16'd1;
          ARB_WR0: wr0Cnt_q <= wr0Cnt_q + 16'd1;
          ARB_WR1: wr1Cnt_q <= wr1Cnt_q + 16'd1;
          default: ;
        endcase
      end
      if (relNow && (waitLen > maxWait_q)) begin
        maxWait_q <= waitLen;
      end
    end
  end

  assign rd_gnt_cnt  = rdCnt_q;
  assign wr0_gnt_cnt = wr0Cnt_q;
  assign wr1_gnt_cnt = wr1Cnt_q;
  assign max_wait    = maxWait_q;
`endif

endmodule

// File: doc/vmem_arbiter.md
Name: vmem_arbiter

Overview:
- Schedules access to the shared DDR memory-controller command/data ports between the display read engine (rd) and two capture write engines (wr0, wr1, left/right eye).
- Each engine is enabled by a one-hot grant and signals completion of its line transfer with a toggle from the memclk domain.
- Sits between the pclk video timing logic and the per-port engines in the video mix core.
- Drives the per-engine memcon_en inputs and the shared arb_state bus.

Parameters:
- GAP_CYC, 4, idle pclk cycles inserted after each release before the next grant (1..255)
- TIMEOUT, 4095, pclk cycles a grant may stay open without completion before forced release (12-bit max)
- STARVE_LIM, 3, consecutive rd grants allowed while any write request is pending before a write gets priority once (1..15)

Ports:
- pclk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_req  in  1  read engine requests a line slot, level
- wr0_req  in  1  write engine 0 request, level
- wr1_req  in  1  write engine 1 request, level
- rd_done_tgl  in  1  memclk-domain toggle, one transition per completed rd line
- wr0_done_tgl  in  1  completion toggle, wr0
- wr1_done_tgl  in  1  completion toggle, wr1
- rd_en  out  1  grant to read engine (memcon_en)
- wr0_en  out  1  grant to wr0
- wr1_en  out  1  grant to wr1
- arb_state  out  2  owner: 00 rd, 01 wr0, 10 wr1, 11 none
- busy  out  1  high in any state except IDLE
- timeout_err  out  1  sticky, set on forced release, cleared only by rst

Behaviour:
- Reset values: all en 0, arb_state 11, busy 0, timeout_err 0, state IDLE, starve counter 0, RR pointer pointing at wr0, timer 0.
- Done toggles pass through a 2-FF synchronizer, then an edge-detect register that tracks continuously in every state.
  - Any toggle transition is one completion event, visible 3 pclk after the input edge.
  - Events are acted on only in WAIT_DONE.
  - An event from a non-owner is ignored.
- States and transitions:
  - IDLE: if any req is high, select a winner and go to GRANT. Otherwise stay in IDLE.
  - GRANT (1 cycle): assert the winner's en and arb_state (registered, visible the cycle after the IDLE decision). Clear the timer. Go to WAIT_DONE.
  - WAIT_DONE: en is held; the timer increments.
    - On the owner's done event: deassert en next cycle, set arb_state 11, go to GAP.
    - If the timer reaches TIMEOUT with no done event: same release, plus set timeout_err.
    - Done and timeout in the same cycle: treated as done; timeout_err is not set.
  - GAP: count GAP_CYC cycles with en all 0, then go to IDLE.
- Withdrawing a req while its grant is open has no effect; the grant stays until done or timeout.
- Winner selection:
  - Normally rd has highest priority.
  - Starve counter:
    - Increments on each rd grant while wr0_req or wr1_req is high.
    - Clears on any write grant.
    - Saturates at STARVE_LIM.
  - When the counter equals STARVE_LIM and a write is pending, the write wins over rd.
  - Among writes, round-robin: the pointer moves to the other write after each write grant. A single requesting write always wins.
- Exactly one en is high at a time, and arb_state always matches it.
- Reset mid-grant: en drops on the cycle after rst is sampled. A stale done toggle arriving after reset only updates the edge-detect register.

Optional Feature:
- Macro VMEM_ARB_STATS_EN.
- With the macro defined:
  - Adds outputs rd_gnt_cnt, wr0_gnt_cnt, wr1_gnt_cnt, each 16-bit, wrapping.
  - Each counter increments in the GRANT cycle for its port.
  - Adds 16-bit max_wait: the largest WAIT_DONE duration seen.
  - All of these reset to 0.
- Without the macro: these ports, and the logic behind them, are absent.

Decomposition:
- Shared package vmem_pkg holds:
  - ARB_RD=2'b00, ARB_WR0=2'b01, ARB_WR1=2'b10, ARB_NONE=2'b11 (also checked by the engines)
  - state encodings IDLE, GRANT, WAIT_DONE, GAP
- One sub-module, tgl_sync_edge: 2-FF synchronizer plus edge detect, instantiated three times.

Test Plan:
- Only rd_req=1 → rd_en=1 and arb_state=00 two cycles after req. Toggle rd_done_tgl → rd_en=0 four cycles later. Grant is re-issued after exactly GAP_CYC=4 idle cycles.
- rd_req, wr0_req and wr1_req all held high, done toggled 20 cycles after each grant → grant order rd,rd,rd,wr0,rd,rd,rd,wr1,rd… with STARVE_LIM=3.
- wr0_req=wr1_req=1, rd_req=0 → grants alternate wr0,wr1,wr0. A wr1 toggle during a wr0 grant is ignored.
- Grant rd and never toggle done → release after 4095 cycles, timeout_err=1 and stays 1 through later grants until rst.
- Done edge arrives in the same cycle the timer hits TIMEOUT → normal release, timeout_err=0.
- Assert rst during WAIT_DONE of wr1 and toggle wr1_done_tgl 2 cycles after rst → all en 0, arb_state 11, no spurious grant. With VMEM_ARB_STATS_EN defined, counters read 0.
